// File: rtl/adc_spi_tx_pkg.sv
// Shared constants, state encoding and input-sync depth for the ADC SPI responder.
// Macro ADC_SPI_TX_SYNC_EN selects two-flop synchronizers (otherwise a single input register).
package adc_spi_pkg;
   localparam int SPI_WIDTH  = 12;
   localparam int LEAD_ZEROS = 4;
   localparam int FRAME_BITS = 32;
   localparam int SLOT_BITS  = LEAD_ZEROS + SPI_WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS);

`ifdef ADC_SPI_TX_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      TAIL
   } state_t;
endpackage

// File: rtl/adc_spi_tx_if.sv
// Parallel sample handshake between the sample source and the SPI responder.
interface adc_spi_tx_if #(
   parameter int W = adc_spi_pkg::SPI_WIDTH
) ();
   logic         samp_valid;
   logic         samp_ready;
   logic [W-1:0] samp_vd;
   logic [W-1:0] samp_id;

   modport master (output samp_valid, output samp_vd, output samp_id, input samp_ready);
   modport slave  (input samp_valid, input samp_vd, input samp_id, output samp_ready);
endinterface

// File: rtl/adc_spi_tx_sync_edge.sv
// Oversamples one serial-side input in the clk domain and flags its edges.
// Macro ADC_SPI_TX_SYNC_EN adds a second synchronizer flop ahead of edge detection.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic rise,
   output logic fall
);
   import adc_spi_pkg::*;

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   level_p1;
   logic                   level;

   assign level = sync_p0[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_p0  <= {SYNC_STAGES{RST_VAL}};
         level_p1 <= RST_VAL;
      end else begin
`ifdef ADC_SPI_TX_SYNC_EN
         sync_p0  <= {sync_p0[0], din};
`else
         sync_p0  <= din;
`endif
         level_p1 <= level;
      end
   end

   // edge compare on registered samples only
   assign rise = level & ~level_p1;
   assign fall = ~level & level_p1;
endmodule

// File: rtl/adc_spi_tx.sv
// SPI responder emulating a dual-channel V/I ADC: buffers one sample pair and shifts
// {zeros, vd, zeros, id} out MSB-first on controller sck falls. Sync depth via ADC_SPI_TX_SYNC_EN.
module adc_spi_tx #(
   parameter int SPI_WIDTH  = adc_spi_pkg::SPI_WIDTH,
   parameter int LEAD_ZEROS = adc_spi_pkg::LEAD_ZEROS,
   parameter int FRAME_BITS = adc_spi_pkg::FRAME_BITS
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cs,
   input  logic        sck,
   output logic        dout,
   adc_spi_tx_if.slave samp,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        stale
);
   import adc_spi_pkg::*;

   localparam int BIT_CNT_W = $clog2(FRAME_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   function automatic logic [FRAME_BITS-1:0] frame_word(input logic [SPI_WIDTH-1:0] vd,
                                                        input logic [SPI_WIDTH-1:0] id);
      return {{LEAD_ZEROS{1'b0}}, vd, {LEAD_ZEROS{1'b0}}, id};
   endfunction

   logic cs_rise, cs_fall, sck_fall, sck_rise_unused;

   sync_edge #(.RST_VAL(1'b1)) u_cs_edge (
      .clk  (clk),
      .n_rst(n_rst),
      .din  (cs),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sck_edge (
      .clk  (clk),
      .n_rst(n_rst),
      .din  (sck),
      .rise (sck_rise_unused),
      .fall (sck_fall)
   );

   state_t                 state;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [FRAME_BITS-1:0]  shreg;
   logic                   hold_full;
   logic [SPI_WIDTH-1:0]   hold_vd, hold_id, last_vd, last_id;
   logic [SPI_WIDTH-1:0]   load_vd, load_id;
   logic [FRAME_BITS-1:0]  load_word;
   logic                   accept, load;

   assign samp.samp_ready = ~hold_full;
   assign accept    = samp.samp_valid & ~hold_full;
   assign load      = (state == IDLE) & cs_fall;
   assign load_vd   = hold_full ? hold_vd : last_vd;
   assign load_id   = hold_full ? hold_id : last_id;
   assign load_word = frame_word(load_vd, load_id);

   // holding buffer payload; qualified by hold_full so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_vd <= samp.samp_vd;
         hold_id <= samp.samp_id;
      end
   end

   // a sample accepted on the load edge lands here for the next frame, never bypassed
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hold_full <= 1'b0;
         last_vd   <= '0;
         last_id   <= '0;
      end else if (load && hold_full) begin
         hold_full <= 1'b0;
         last_vd   <= hold_vd;
         last_id   <= hold_id;
      end else if (accept) begin
         hold_full <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load)
         shreg <= load_word;
      else if (state == SHIFT && cs_rise)
         shreg <= '0;
      else if (state == SHIFT && sck_fall)
         shreg <= shreg << 1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         dout        <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         stale       <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         stale       <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  dout    <= load_word[FRAME_BITS-1];
                  stale   <= ~hold_full;
               end
            end
            SHIFT: begin
               // cs release wins over a coincident sck fall
               if (cs_rise) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  dout        <= 1'b0;
                  frame_abort <= 1'b1;
               end else if (sck_fall) begin
                  if (bit_cnt == LAST_BIT) begin
                     state      <= TAIL;
                     dout       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     dout    <= shreg[FRAME_BITS-2];
                  end
               end
            end
            TAIL: begin
               dout <= 1'b0;
               if (cs_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               dout  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_adc_spi_tx.sv
// Randomized scoreboard bench for adc_spi_tx: a driver plays SPI controller and sample
// source, a sample-queue model predicts every frame, and a monitor checks each frame end.
module tb_adc_spi_tx;
   import adc_spi_pkg::*;

   localparam int L = SYNC_STAGES + 1;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic cs = 1'b1;
   logic sck = 1'b0;
   logic dout, busy, frame_done, frame_abort, stale;

   adc_spi_tx_if sif ();

   adc_spi_tx dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .cs         (cs),
      .sck        (sck),
      .dout       (dout),
      .samp       (sif),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_abort(frame_abort),
      .stale      (stale)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] bits;
      int          done;
      int          abort;
      int          stl;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   logic [63:0] cap;
   int          cap_n;

   // reference model: one-entry buffer plus last-sent pair
   bit                   m_full;
   logic [SPI_WIDTH-1:0] m_hvd, m_hid, m_lvd, m_lid;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_full = 0; m_hvd = '0; m_hid = '0; m_lvd = '0; m_lid = '0;
   endfunction

   function automatic void m_write(input logic [SPI_WIDTH-1:0] vd, input logic [SPI_WIDTH-1:0] id);
      m_full = 1; m_hvd = vd; m_hid = id;
   endfunction

   function automatic logic [31:0] m_take(output int st);
      if (m_full) begin
         m_lvd = m_hvd; m_lid = m_hid; m_full = 0; st = 0;
      end else begin
         st = 1;
      end
      return 32'(int'(m_lvd) * 65536 + int'(m_lid));
   endfunction

   function automatic exp_t m_frame(input int nbits, input logic [31:0] word, input int st);
      exp_t e;
      e.bits = '0;
      for (int i = 0; i < nbits; i++)
         e.bits = {e.bits[62:0], (i < 32) ? word[31-i] : 1'b0};
      e.done  = (nbits >= 32) ? 1 : 0;
      e.abort = (nbits < 32) ? 1 : 0;
      e.stl   = st;
      return e;
   endfunction

   task automatic write_samp(input logic [SPI_WIDTH-1:0] vd, input logic [SPI_WIDTH-1:0] id);
      @(negedge clk);
      sif.samp_valid = 1'b1; sif.samp_vd = vd; sif.samp_id = id;
      chk("ready_before_write", sif.samp_ready, 1);
      @(negedge clk);
      sif.samp_valid = 1'b0;
      chk("ready_after_write", sif.samp_ready, 0);
      m_write(vd, id);
   endtask

   task automatic clock_bits(input int nbits);
      for (int i = 0; i < nbits; i++) begin
         sck = 1'b1;
         cap = {cap[62:0], dout};
         cap_n++;
         repeat (4) @(negedge clk);
         sck = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic run_frame(input int nbits, input bit wr_on_load,
                            input logic [SPI_WIDTH-1:0] vd, input logic [SPI_WIDTH-1:0] id);
      int st;
      logic [31:0] w;
      w = m_take(st);
      sb.push_back(m_frame(nbits, w, st));
      @(negedge clk);
      cap = '0; cap_n = 0; cs = 1'b0;
      if (wr_on_load) begin
         repeat (L - 1) @(negedge clk);
         sif.samp_valid = 1'b1; sif.samp_vd = vd; sif.samp_id = id;
         @(negedge clk);
         sif.samp_valid = 1'b0;
         m_write(vd, id);
         repeat (4 - L) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      clock_bits(nbits);
      cs = 1'b1;
      repeat (L + 4) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, sif.samp_ready, 1);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_abort"}, frame_abort, 0);
      chk({tag, "_stale"}, stale, 0);
   endtask

   // monitor: counts pulses per frame and scores each frame when busy drops
   int   nd = 0, na = 0, ns = 0;
   logic busy_q = 1'b0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            nd = 0; na = 0; ns = 0; busy_q = 1'b0;
         end else begin
            if (frame_done)  nd++;
            if (frame_abort) na++;
            if (stale)       ns++;
            if (busy_q && !busy) begin
               if (sb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL sb_underflow got=frame_end expected=no_frame at %0t", $time);
               end else begin
                  mon_e = sb.pop_front();
                  chk("frame_bits", cap, mon_e.bits);
                  chk("frame_done_cnt", 64'(nd), 64'(mon_e.done));
                  chk("frame_abort_cnt", 64'(na), 64'(mon_e.abort));
                  chk("stale_cnt", 64'(ns), 64'(mon_e.stl));
                  chk("dout_after_frame", dout, 0);
               end
               nd = 0; na = 0; ns = 0;
            end
            busy_q = busy;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SPI_WIDTH-1:0] rv, ri;
      int nb;
      sif.samp_valid = 1'b0; sif.samp_vd = '0; sif.samp_id = '0;
      m_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      n_rst = 1'b1;
      repeat (4) @(negedge clk);

      // empty buffer after reset: two stale all-zero frames, then a fresh pair
      run_frame(32, 0, '0, '0);
      run_frame(32, 0, '0, '0);
      write_samp(12'hFFF, 12'h001);
      run_frame(32, 0, '0, '0);

      write_samp(12'hABC, 12'h123);
      run_frame(32, 0, '0, '0);
      chk("ready_after_load", sif.samp_ready, 1);

      // abort after 10 falls, then the aborted pair repeats as stale
      write_samp(12'h5A5, 12'h3C3);
      run_frame(10, 0, '0, '0);
      chk("abort_busy", busy, 0);
      run_frame(32, 0, '0, '0);

      // overlong frame: trailing bits must read zero, one frame_done
      write_samp(12'h800, 12'h7FF);
      run_frame(40, 0, '0, '0);

      // sample offered on the load edge goes to the following frame
      run_frame(32, 1, 12'h246, 12'h9BD);
      chk("ready_after_load_write", sif.samp_ready, 0);
      run_frame(32, 0, '0, '0);

      // reset mid-frame at bit 16
      write_samp(12'h111, 12'h222);
      begin
         int st;
         logic [31:0] w;
         w = m_take(st);
      end
      @(negedge clk);
      cap = '0; cap_n = 0; cs = 1'b0;
      repeat (4) @(negedge clk);
      clock_bits(16);
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1 check_reset_outputs("midreset");
      cs = 1'b1; sck = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      m_reset();
      repeat (4) @(negedge clk);
      write_samp(12'hC0F, 12'hFEE);
      run_frame(32, 0, '0, '0);

      for (int k = 0; k < 10; k++) begin
         rv = SPI_WIDTH'($urandom);
         ri = SPI_WIDTH'($urandom);
         if (!m_full && $urandom_range(0, 2) != 0) write_samp(rv, ri);
         case ($urandom_range(0, 3))
            0:       nb = $urandom_range(1, 31);
            3:       nb = $urandom_range(33, 40);
            default: nb = 32;
         endcase
         run_frame(nb, 0, '0, '0);
      end

      repeat (10) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
